serial_add_sub_multichannel: RTL and testbench

Digit-serial adder/subtractor that processes operands LSB-first, DIGIT_W bits per accepted beat. It keeps independent carry/mode state for NUM_CH interleaved channels. Operands arrive as framed packets (first/last markers) over a valid/ready stream, and results leave over a registered valid/ready stream. On the last digit the block reports unsigned carry-out and signed overflow. It sits in the sequential-arithmetic group and is the generalised, streaming successor of the 1-bit serial adder.

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/serial_add_sub_multichannel_if.sv | 34 +++
 rtl/digit_full_adder.sv | 24 ++
 rtl/serial_add_sub_multichannel.sv | 103 ++++++++++
 tb/tb_serial_add_sub_multichannel.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } mode_e;

   // Channel-id width; a single channel still gets a 1-bit id.
   function automatic int ch_w_calc(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/serial_add_sub_multichannel_if.sv
// Operand-in / result-out streams of the multichannel serial adder.
interface serial_add_sub_multichannel_if #(
   parameter int DIGIT_W = 4,
   parameter int CH_W    = 1
);
   logic               in_valid;
   logic               in_ready;
   logic [CH_W-1:0]    in_ch;
   logic               in_first;
   logic               in_last;
   logic               in_sub;
   logic [DIGIT_W-1:0] a;
   logic [DIGIT_W-1:0] b;

   logic               out_valid;
   logic               out_ready;
   logic [CH_W-1:0]    out_ch;
   logic               out_last;
   logic [DIGIT_W-1:0] sum;
   logic               out_carry;
   logic               out_overflow;

   // Arithmetic block side
   modport slave (
      input  in_valid, in_ch, in_first, in_last, in_sub, a, b, out_ready,
      output in_ready, out_valid, out_ch, out_last, sum, out_carry, out_overflow
   );

   // Producer / consumer side
   modport master (
      output in_valid, in_ch, in_first, in_last, in_sub, a, b, out_ready,
      input  in_ready, out_valid, out_ch, out_last, sum, out_carry, out_overflow
   );
endinterface

// File: rtl/digit_full_adder.sv
// Combinational ripple of DIGIT_W full adders built from logic ops only.
module digit_full_adder #(
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] a_i,
   input  logic [DIGIT_W-1:0] b_i,
   input  logic               cin_i,
   output logic [DIGIT_W-1:0] sum_o,
   output logic               cout_o,
   output logic               cmsb_o
);
   logic [DIGIT_W:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
   end

   assign cout_o = c[DIGIT_W];
   // Carry into the MSB; XOR with cout gives signed overflow.
   assign cmsb_o = c[DIGIT_W-1];
endmodule

// File: rtl/serial_add_sub_multichannel.sv
// Digit-serial add/sub, LSB first, with per-channel carry/mode state and a
// single registered output stage (1 beat/cycle, 1 cycle latency).
module serial_add_sub_multichannel
   import serial_arith_pkg::*;
#(
   parameter int DIGIT_W = 4,
   parameter int NUM_CH  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   serial_add_sub_multichannel_if.slave  bus
);
   localparam int CH_W = ch_w_calc(NUM_CH);

   logic [NUM_CH-1:0]  carry_q, carry_d;
   logic [NUM_CH-1:0]  sub_q,   sub_d;
   logic               out_valid_q, out_valid_d;
   logic [DIGIT_W-1:0] sum_q,   sum_d;
   logic [CH_W-1:0]    ch_q,    ch_d;
   logic               last_q,  last_d;
   logic               carry_o_q, carry_o_d;
   logic               ovf_q,   ovf_d;

   logic [CH_W-1:0]    ch;
   logic               accept;
   mode_e              mode;
   logic               cin;
   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W-1:0] dsum;
   logic               cout;
   logic               cmsb;

   assign ch          = bus.in_ch;
   assign bus.in_ready = ~out_valid_q | bus.out_ready;
   assign accept      = bus.in_valid & bus.in_ready;

   // A first beat opens a packet: mode and carry-in come from in_sub, which
   // also abandons any packet still open on that channel.
   assign mode  = bus.in_first ? mode_e'(bus.in_sub) : mode_e'(sub_q[ch]);
   assign cin   = bus.in_first ? bus.in_sub : carry_q[ch];
   assign b_eff = (mode == SUB) ? ~bus.b : bus.b;

   digit_full_adder #(.DIGIT_W(DIGIT_W)) u_add (
      .a_i    (bus.a),
      .b_i    (b_eff),
      .cin_i  (cin),
      .sum_o  (dsum),
      .cout_o (cout),
      .cmsb_o (cmsb)
   );

   // Next state: only the addressed channel moves, and only on accept.
   always_comb begin
      carry_d     = carry_q;
      sub_d       = sub_q;
      out_valid_d = out_valid_q & ~bus.out_ready;
      sum_d       = sum_q;
      ch_d        = ch_q;
      last_d      = last_q;
      carry_o_d   = carry_o_q;
      ovf_d       = ovf_q;
      if (accept) begin
         carry_d[ch] = bus.in_last ? 1'b0 : cout;
         sub_d[ch]   = bus.in_last ? 1'b0 : (mode == SUB);
         out_valid_d = 1'b1;
         sum_d       = dsum;
         ch_d        = ch;
         last_d      = bus.in_last;
         carry_o_d   = bus.in_last & cout;
         ovf_d       = bus.in_last & (cout ^ cmsb);
      end
   end

   // State and output registers; reset drops any pending output.
   always_ff @(posedge clk) begin
      if (!rst) begin
         carry_q     <= '0;
         sub_q       <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         ch_q        <= '0;
         last_q      <= 1'b0;
         carry_o_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         carry_q     <= carry_d;
         sub_q       <= sub_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         ch_q        <= ch_d;
         last_q      <= last_d;
         carry_o_q   <= carry_o_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.sum          = sum_q;
   assign bus.out_ch       = ch_q;
   assign bus.out_last     = last_q;
   assign bus.out_carry    = carry_o_q;
   assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub_multichannel.sv
// Bench for serial_add_sub_multichannel: directed packets plus random
// interleaved traffic against a whole-operand arithmetic model.
module tb_serial_add_sub_multichannel;
   import serial_arith_pkg::*;

   localparam int DW  = 4;
   localparam int NCH = 2;
   localparam int CW  = ch_w_calc(NCH);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   serial_add_sub_multichannel_if #(.DIGIT_W(DW), .CH_W(CW)) bus ();

   serial_add_sub_multichannel #(.DIGIT_W(DW), .NUM_CH(NCH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [DW-1:0] sum;
      int            ch;
      int            idx;
      logic          last;
      logic          carry;
      logic          ovf;
   } exp_t;

   exp_t   exp_q[$];
   int     n_chk = 0;
   int     n_err = 0;

   // Model: operands accumulated as whole integers per channel.
   longint m_a[NCH], m_b[NCH];
   int     m_n[NCH];
   bit     m_sub[NCH];
   // Observed results reassembled from output digits.
   longint obs_v[NCH], res[NCH];
   logic   res_c[NCH], res_o[NCH];
   int     rem[NCH];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Result digit k of a packet = digit k of (A op B) over the first k+1 digits.
   function automatic exp_t model(input int ch, input bit f, input bit l,
                                  input bit s, input longint a, input longint b);
      exp_t   e;
      longint full, mask, half, sa, sb, r;
      int     w;
      if (f) begin
         m_a[ch] = 0; m_b[ch] = 0; m_n[ch] = 0; m_sub[ch] = s;
      end
      m_a[ch] |= a << (DW * m_n[ch]);
      m_b[ch] |= b << (DW * m_n[ch]);
      e.idx = m_n[ch];
      m_n[ch]++;
      w    = DW * m_n[ch];
      mask = (64'sd1 << w) - 1;
      half = 64'sd1 << (w - 1);
      full = m_sub[ch] ? m_a[ch] + (~m_b[ch] & mask) + 1 : m_a[ch] + m_b[ch];
      e.sum = DW'(full >> (w - DW));
      sa = (m_a[ch] >= half) ? m_a[ch] - (half << 1) : m_a[ch];
      sb = (m_b[ch] >= half) ? m_b[ch] - (half << 1) : m_b[ch];
      r  = m_sub[ch] ? sa - sb : sa + sb;
      e.carry = l && (((full >> w) & 1) != 0);
      e.ovf   = l && (r < -half || r >= half);
      e.ch    = ch;
      e.last  = l;
      if (l) begin
         m_a[ch] = 0; m_b[ch] = 0; m_n[ch] = 0; m_sub[ch] = 0;
      end
      return e;
   endfunction

   // One cycle, entered and left just after a falling edge.
   task automatic step(input int ch, input bit v, input bit f, input bit l, input bit s,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit rdy, output bit acc);
      exp_t e;
      chk("out_valid", bus.out_valid, exp_q.size() > 0);
      if (bus.out_valid && exp_q.size() > 0) begin
         e = exp_q[0];
         chk("sum", bus.sum, e.sum);
         chk("out_ch", bus.out_ch, e.ch);
         chk("out_last", bus.out_last, e.last);
         chk("out_carry", bus.out_carry, e.carry);
         chk("out_overflow", bus.out_overflow, e.ovf);
      end
      bus.in_valid  = v;
      bus.in_ch     = CW'(ch);
      bus.in_first  = f;
      bus.in_last   = l;
      bus.in_sub    = s;
      bus.a         = a;
      bus.b         = b;
      bus.out_ready = rdy;
      #1;
      chk("in_ready", bus.in_ready, !bus.out_valid || rdy);
      if (bus.out_valid && rdy && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.idx == 0) obs_v[e.ch] = 0;
         obs_v[e.ch] |= longint'(bus.sum) << (DW * e.idx);
         if (e.last) begin
            res[e.ch]   = obs_v[e.ch];
            res_c[e.ch] = bus.out_carry;
            res_o[e.ch] = bus.out_overflow;
         end
      end
      acc = v && bus.in_ready;
      if (acc) exp_q.push_back(model(ch, f, l, s, longint'(a), longint'(b)));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input int ch, input bit f, input bit l, input bit s,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit acc = 0;
      for (int t = 0; t < 20 && !acc; t++) step(ch, 1, f, l, s, a, b, 1, acc);
      chk("send_timeout", acc, 1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, '0, 1, acc);
   endtask

   task automatic pkt(input int ch, input bit s, input logic [31:0] a,
                      input logic [31:0] b, input int n);
      for (int i = 0; i < n; i++)
         send(ch, i == 0, i == n - 1, s, a[DW*i +: DW], b[DW*i +: DW]);
   endtask

   task automatic chk_res(input string tag, input int ch, input longint v,
                          input logic c, input logic o);
      chk(tag, res[ch], v);
      chk({tag, "_carry"}, res_c[ch], c);
      chk({tag, "_ovf"}, res_o[ch], o);
   endtask

   task automatic do_reset();
      bus.in_valid  = 0;
      bus.out_ready = 0;
      rst = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      exp_q.delete();
      for (int c = 0; c < NCH; c++) begin
         m_a[c] = 0; m_b[c] = 0; m_n[c] = 0; m_sub[c] = 0;
      end
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_out_ch", bus.out_ch, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_carry", bus.out_carry, 0);
      chk("rst_out_ovf", bus.out_overflow, 0);
      chk("rst_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      bit acc;
      bus.in_valid = 0; bus.in_ch = '0; bus.in_first = 0; bus.in_last = 0;
      bus.in_sub = 0; bus.a = '0; bus.b = '0; bus.out_ready = 0;
      for (int c = 0; c < NCH; c++) begin
         res[c] = -1; res_c[c] = 1'bx; res_o[c] = 1'bx; obs_v[c] = 0; rem[c] = 0;
      end
      @(negedge clk);
      do_reset();

      // Directed arithmetic
      pkt(0, 0, 'h1234, 'h0FCD, 4); idle(2); chk_res("add_1234", 0, 'h2201, 0, 0);
      pkt(1, 1, 'h05, 'h07, 2);     idle(2); chk_res("sub_05_07", 1, 'hFE, 0, 0);
      pkt(0, 0, 'h7F, 'h01, 2);     idle(2); chk_res("add_7f", 0, 'h80, 0, 1);
      pkt(1, 0, 'hFF, 'h01, 2);     idle(2); chk_res("add_ff", 1, 'h00, 1, 0);
      pkt(0, 1, 'h3, 'h5, 1);       idle(2); chk_res("single_sub", 0, 'hE, 0, 0);
      pkt(1, 0, 'h7, 'h1, 1);       idle(2); chk_res("single_add", 1, 'h8, 0, 1);

      // Interleaved channels
      for (int i = 0; i < 4; i++) begin
         send(0, i == 0, i == 3, 0, DW'('h1234 >> (DW*i)), DW'('h0FCD >> (DW*i)));
         if (i < 2) send(1, i == 0, i == 1, 1, DW'('h05 >> (DW*i)), DW'('h07 >> (DW*i)));
      end
      idle(2);
      chk_res("ilv_ch0", 0, 'h2201, 0, 0);
      chk_res("ilv_ch1", 1, 'hFE, 0, 0);

      // Abandoned packet: a new first beat restarts the channel
      send(0, 1, 0, 0, 'h9, 'h9);
      pkt(0, 1, 'h05, 'h07, 2); idle(2); chk_res("abandon", 0, 'hFE, 0, 0);

      // Output stall for 3 cycles mid-packet, then 1 beat/cycle
      send(0, 1, 0, 0, 'h4, 'hD);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 0, 0, 0, 'h3, 'hC, 0, acc);
         chk("stall_acc", acc, 0);
      end
      for (int i = 1; i < 4; i++) begin
         step(0, 1, 0, i == 3, 0, DW'('h1234 >> (DW*i)), DW'('h0FCD >> (DW*i)), 1, acc);
         chk("b2b_acc", acc, 1);
      end
      idle(2); chk_res("stall", 0, 'h2201, 0, 0);

      // Reset mid-packet: the remaining digits run as a fresh add with cin 0
      send(0, 1, 0, 0, 'h4, 'hD);
      send(0, 0, 0, 0, 'h3, 'hC);
      do_reset();
      send(0, 0, 0, 0, 'h2, 'hF);
      send(0, 0, 1, 0, 'h1, 'h0);
      idle(2); chk_res("rst_cont", 0, 'h21, 0, 0);
      pkt(0, 0, 'h1234, 'h0FCD, 4); idle(2); chk_res("rst_fresh", 0, 'h2201, 0, 0);

      // Random interleaved traffic with backpressure and one reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int  ch, r;
         bit  f, v;
         ch = int'($urandom_range(NCH - 1, 0));
         v  = ($urandom_range(4, 0) != 0);
         f  = (rem[ch] == 0) || ($urandom_range(19, 0) == 0);
         r  = f ? int'($urandom_range(6, 1)) : rem[ch];
         step(ch, v, f, r == 1, $urandom_range(1, 0) != 0,
              DW'($urandom), DW'($urandom), $urandom_range(3, 0) != 0, acc);
         if (acc) rem[ch] = r - 1;
         if (cyc == 1500) do_reset();
      end
      idle(3);
      chk("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
